inst_fetch_queue: RTL

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue_pkg.sv | 20 ++
 rtl/inst_fetch_queue_fetch_fifo.sv | 83 ++++++++
 rtl/inst_fetch_queue.sv | 130 +++++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: machine width,
// NOP encoding, PC step, the buffered entry layout and an alignment helper.
package inst_fetch_queue_pkg;

    localparam int unsigned      XLEN     = 32;
    localparam logic [XLEN-1:0]  NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0]  PC_INC   = 32'h0000_0004;

    // One buffered instruction: where it came from and what it is.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} entries. Writes land on the
// clock edge and are only visible on the read side the following cycle.
module fetch_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   wr_en,
    input  fetch_entry_t           wr_data,
    input  logic                   rd_en,
    output fetch_entry_t           rd_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr_s, do_rd_s;

    // Next state of storage, pointers and occupancy; a flush overrides both ports
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_wr_s  = wr_en && (count_q != FULL_CNT);
        do_rd_s  = rd_en && (count_q != CNT_ZERO);
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (do_wr_s) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_rd_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register for storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches under a credit
// limit, buffers returned instructions for decode, and on a redirect flushes
// the buffer and silently discards every response still in flight.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_pc_4,
    output logic [XLEN-1:0] dec_inst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned      CNT_W     = $clog2(DEPTH) + 1;
    localparam int unsigned      SUM_W     = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    // Requests between flushes are strictly sequential, so the in-order
    // address record reduces to the PC of the oldest unanswered request.
    logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [CNT_W-1:0] occupancy_s;
    logic [SUM_W-1:0] credit_used_s;
    logic             req_fire_s, rsp_acc_s, rsp_keep_s, deq_s;
    fetch_entry_t     fifo_wdata_s, head_s;

    // Request credit check and the handshakes that move state this cycle
    always_comb begin
        credit_used_s  = SUM_W'(occupancy_s) + SUM_W'(outstanding_q);
        imem_req_valid = !rst && !redirect && (credit_used_s < DEPTH_SUM)
                         && (drop_q == CNT_ZERO);
        imem_req_addr  = fetch_pc_q;
        req_fire_s     = imem_req_valid && imem_req_ready;
        // A response with nothing in flight is stale (e.g. from before reset)
        rsp_acc_s      = imem_rsp_valid && (outstanding_q != CNT_ZERO);
        rsp_keep_s     = rsp_acc_s && (drop_q == CNT_ZERO) && !redirect;
        deq_s          = dec_valid && dec_ready && !redirect;
        fifo_wdata_s   = {rsp_pc_q, imem_rsp_data};
    end

    // Next state of fetch PC, response PC, in-flight and discard counters
    always_comb begin
        case ({req_fire_s, rsp_acc_s})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (redirect) begin
            // Everything still in flight after this cycle is now garbage
            drop_d     = outstanding_q - CNT_W'(rsp_acc_s);
            fetch_pc_d = word_align(redirect_pc);
            rsp_pc_d   = word_align(redirect_pc);
        end else begin
            if (rsp_acc_s && (drop_q != CNT_ZERO)) begin
                drop_d = drop_q - CNT_W'(1);
            end else begin
                drop_d = drop_q;
            end
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + PC_INC;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_keep_s) begin
                rsp_pc_d = rsp_pc_q + PC_INC;
            end else begin
                rsp_pc_d = rsp_pc_q;
            end
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= CNT_ZERO;
            drop_q        <= CNT_ZERO;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect),
        .wr_en   (rsp_keep_s),
        .wr_data (fifo_wdata_s),
        .rd_en   (deq_s),
        .rd_data (head_s),
        .count   (occupancy_s)
    );

    // Decode-side view of the head entry; idle values when the queue is empty
    always_comb begin
        dec_valid = (occupancy_s != CNT_ZERO);
        if (dec_valid) begin
            dec_pc   = head_s.pc;
            dec_pc_4 = head_s.pc + PC_INC;
            dec_inst = head_s.inst;
        end else begin
            dec_pc   = 32'h0000_0000;
            dec_pc_4 = 32'h0000_0000;
            dec_inst = NOP_INST;
        end
    end

endmodule
